// File: rtl/decode_stall_bubble_if.sv
// Signal bundle between the hazard/fetch logic and the decode stall/bubble controller.
// The controller takes the slave view; whatever drives fetch and hazards takes the master view.
interface decode_stall_bubble_if;
  logic        stall;
  logic        flush;
  logic [31:0] f_pc;
  logic [31:0] f_inst;
  logic        f_valid;
  logic        pc_enable;
  logic [31:0] d_pc;
  logic [31:0] d_inst;
  logic        d_valid;
  logic [31:0] x_pc;
  logic [31:0] x_inst;
  logic        x_valid;
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
  logic        deadlock;

  modport master (
    output stall, flush, f_pc, f_inst, f_valid,
    input  pc_enable, d_pc, d_inst, d_valid, x_pc, x_inst, x_valid,
    input  stall_cycles, flush_count, deadlock
  );

  modport slave (
    input  stall, flush, f_pc, f_inst, f_valid,
    output pc_enable, d_pc, d_inst, d_valid, x_pc, x_inst, x_valid,
    output stall_cycles, flush_count, deadlock
  );
endinterface

// File: rtl/decode_stall_bubble.sv
// F/D and D/X pipeline registers with stall (freeze + bubble) and flush (squash) control,
// saturating stall/flush performance counters and a sticky stall-deadlock watchdog.
module decode_stall_bubble #(
  parameter logic [31:0] NOP_INST    = 32'h0000_0013,
  parameter int unsigned STALL_LIMIT = 64
) (
  input logic                  clock,
  input logic                  reset,
  decode_stall_bubble_if.slave bus
);

  localparam logic [15:0] Limit = 16'(STALL_LIMIT);

  typedef enum logic [1:0] {
    StIdle,
    StStalling,
    StLocked
  } wd_state_e;

  logic        do_flush;
  logic        do_stall;

  logic [31:0] d_pc_q, d_pc_d;
  logic [31:0] d_inst_q, d_inst_d;
  logic        d_valid_q, d_valid_d;
  logic [31:0] x_pc_q, x_pc_d;
  logic [31:0] x_inst_q, x_inst_d;
  logic        x_valid_q, x_valid_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;
  logic [15:0] run_len_q, run_len_d;
  wd_state_e   wd_state_q, wd_state_d;

  // Flush wins over stall; a stall only counts when no flush is present.
  assign do_flush = bus.flush;
  assign do_stall = bus.stall & ~bus.flush;

  // The PC must still load the redirect target when a flush coincides with a stall.
  assign bus.pc_enable = ~bus.stall | bus.flush;

  always_comb begin
    d_pc_d    = d_pc_q;
    d_inst_d  = d_inst_q;
    d_valid_d = d_valid_q;
    x_pc_d    = x_pc_q;
    x_inst_d  = x_inst_q;
    x_valid_d = x_valid_q;
    if (do_flush) begin
      d_pc_d    = bus.f_pc;
      d_inst_d  = NOP_INST;
      d_valid_d = 1'b0;
      x_pc_d    = d_pc_q;
      x_inst_d  = NOP_INST;
      x_valid_d = 1'b0;
    end else if (do_stall) begin
      x_pc_d    = d_pc_q;
      x_inst_d  = NOP_INST;
      x_valid_d = 1'b0;
    end else begin
      d_pc_d    = bus.f_pc;
      d_inst_d  = bus.f_valid ? bus.f_inst : NOP_INST;
      d_valid_d = bus.f_valid;
      x_pc_d    = d_pc_q;
      x_inst_d  = d_inst_q;
      x_valid_d = d_valid_q;
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (do_stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
    if (do_flush && (flush_count_q != 32'hFFFF_FFFF)) begin
      flush_count_d = flush_count_q + 32'd1;
    end
  end

  always_comb begin
    wd_state_d = wd_state_q;
    run_len_d  = 16'd0;
    if (do_stall) begin
      run_len_d = (run_len_q == Limit) ? run_len_q : run_len_q + 16'd1;
    end
    case (wd_state_q)
      StIdle: begin
        if (do_stall) begin
          wd_state_d = StStalling;
        end
      end
      StStalling: begin
        if (!do_stall) begin
          wd_state_d = StIdle;
        end else if (run_len_q + 16'd1 == Limit) begin
          wd_state_d = StLocked;
        end
      end
      StLocked: begin
        wd_state_d = StLocked;
      end
      default: begin
        wd_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      d_pc_q         <= 32'd0;
      d_inst_q       <= NOP_INST;
      d_valid_q      <= 1'b0;
      x_pc_q         <= 32'd0;
      x_inst_q       <= NOP_INST;
      x_valid_q      <= 1'b0;
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 32'd0;
      run_len_q      <= 16'd0;
      wd_state_q     <= StIdle;
    end else begin
      d_pc_q         <= d_pc_d;
      d_inst_q       <= d_inst_d;
      d_valid_q      <= d_valid_d;
      x_pc_q         <= x_pc_d;
      x_inst_q       <= x_inst_d;
      x_valid_q      <= x_valid_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
      run_len_q      <= run_len_d;
      wd_state_q     <= wd_state_d;
    end
  end

  assign bus.d_pc         = d_pc_q;
  assign bus.d_inst       = d_inst_q;
  assign bus.d_valid      = d_valid_q;
  assign bus.x_pc         = x_pc_q;
  assign bus.x_inst       = x_inst_q;
  assign bus.x_valid      = x_valid_q;
  assign bus.stall_cycles = stall_cycles_q;
  assign bus.flush_count  = flush_count_q;
  assign bus.deadlock     = (wd_state_q == StLocked);

endmodule

// File: tb/tb_decode_stall_bubble.sv
// Scoreboard bench: stimulus pushes model predictions, a monitor pops and compares each cycle.
module tb_decode_stall_bubble;
  localparam logic [31:0] Nop   = 32'h0000_0013;
  localparam int          Limit = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  bit   active = 1'b0;

  decode_stall_bubble_if bus ();

  decode_stall_bubble #(
    .NOP_INST   (Nop),
    .STALL_LIMIT(Limit)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        pc_en;
    logic [31:0] d_pc, d_inst;
    logic        d_valid;
    logic [31:0] x_pc, x_inst;
    logic        x_valid;
    logic [31:0] sc, fc;
    logic        dl;
  } exp_t;

  exp_t q[$];

  // Reference model state
  logic [31:0] m_d_pc, m_d_inst, m_x_pc, m_x_inst, m_sc, m_fc;
  logic        m_d_valid, m_x_valid, m_dl;
  int          m_run;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_d_pc = 0; m_d_inst = Nop; m_d_valid = 0;
    m_x_pc = 0; m_x_inst = Nop; m_x_valid = 0;
    m_sc = 0; m_fc = 0; m_dl = 0; m_run = 0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_d_pc"}, bus.d_pc, 32'd0);
    chk({tag, "_d_inst"}, bus.d_inst, Nop);
    chk({tag, "_d_valid"}, {31'd0, bus.d_valid}, 32'd0);
    chk({tag, "_x_pc"}, bus.x_pc, 32'd0);
    chk({tag, "_x_inst"}, bus.x_inst, Nop);
    chk({tag, "_x_valid"}, {31'd0, bus.x_valid}, 32'd0);
    chk({tag, "_stall_cycles"}, bus.stall_cycles, 32'd0);
    chk({tag, "_flush_count"}, bus.flush_count, 32'd0);
    chk({tag, "_deadlock"}, {31'd0, bus.deadlock}, 32'd0);
  endtask

  // Called at a negedge: drive inputs, predict next-edge state, wait one cycle.
  task automatic cycle(input bit s, input bit f, input logic [31:0] pc, input logic [31:0] inst,
                       input bit v);
    exp_t e;
    bus.stall = s; bus.flush = f; bus.f_pc = pc; bus.f_inst = inst; bus.f_valid = v;
    e.pc_en = !s || f;
    if (f) begin
      m_x_pc = m_d_pc; m_x_inst = Nop; m_x_valid = 0;
      m_d_pc = pc; m_d_inst = Nop; m_d_valid = 0;
      if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
      m_run = 0;
    end else if (s) begin
      m_x_pc = m_d_pc; m_x_inst = Nop; m_x_valid = 0;
      if (m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
      if (m_run < Limit) m_run++;
      if (m_run == Limit) m_dl = 1;
    end else begin
      m_x_pc = m_d_pc; m_x_inst = m_d_inst; m_x_valid = m_d_valid;
      m_d_pc = pc; m_d_inst = v ? inst : Nop; m_d_valid = v;
      m_run = 0;
    end
    e.d_pc = m_d_pc; e.d_inst = m_d_inst; e.d_valid = m_d_valid;
    e.x_pc = m_x_pc; e.x_inst = m_x_inst; e.x_valid = m_x_valid;
    e.sc = m_sc; e.fc = m_fc; e.dl = m_dl;
    q.push_back(e);
    @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    active = 0;
    q.delete();
    reset = 1;
    bus.stall = 0; bus.flush = 0; bus.f_pc = 0; bus.f_inst = 0; bus.f_valid = 0;
    @(negedge clock);
    check_reset("reset");
    reset = 0;
    model_reset();
    active = 1;
  endtask

  // Monitor: pc_enable sampled at the edge, registered outputs just after it.
  initial begin
    exp_t e;
    logic pe;
    forever begin
      @(posedge clock);
      pe = bus.pc_enable;
      #1;
      if (active && q.size() > 0) begin
        e = q.pop_front();
        chk("pc_enable", {31'd0, pe}, {31'd0, e.pc_en});
        chk("d_pc", bus.d_pc, e.d_pc);
        chk("d_inst", bus.d_inst, e.d_inst);
        chk("d_valid", {31'd0, bus.d_valid}, {31'd0, e.d_valid});
        chk("x_pc", bus.x_pc, e.x_pc);
        chk("x_inst", bus.x_inst, e.x_inst);
        chk("x_valid", {31'd0, bus.x_valid}, {31'd0, e.x_valid});
        chk("stall_cycles", bus.stall_cycles, e.sc);
        chk("flush_count", bus.flush_count, e.fc);
        chk("deadlock", {31'd0, bus.deadlock}, {31'd0, e.dl});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] pc;
    model_reset();
    do_reset();

    // Straight-line flow
    cycle(0, 0, 32'h100, 32'h0010_0093, 1);
    chk("flow_d_pc_e1", bus.d_pc, 32'h100);
    cycle(0, 0, 32'h104, 32'h0020_0113, 1);
    chk("flow_x_pc_e2", bus.x_pc, 32'h100);
    chk("flow_d_pc_e2", bus.d_pc, 32'h104);
    // Two-cycle stall with d_pc=0x104
    cycle(1, 0, 32'h108, 32'h0030_0193, 1);
    cycle(1, 0, 32'h108, 32'h0030_0193, 1);
    chk("stall_d_hold", bus.d_pc, 32'h104);
    chk("stall_x_bubble", bus.x_inst, Nop);
    cycle(0, 0, 32'h108, 32'h0030_0193, 1);
    chk("stall_release_x_pc", bus.x_pc, 32'h104);
    chk("stall_count_2", bus.stall_cycles, 32'd2);
    // Flush with d_pc=0x108, f_pc=0x10C, then flush+stall together
    cycle(1, 1, 32'h10C, 32'h0040_0213, 1);
    chk("flush_d_valid", {31'd0, bus.d_valid}, 32'd0);
    chk("flush_count_1", bus.flush_count, 32'd1);
    cycle(1, 1, 32'h200, 32'h0050_0293, 1);
    chk("flush_stall_sc", bus.stall_cycles, 32'd2);

    // Watchdog: 3 stalls, gap, 4 stalls
    do_reset();
    repeat (3) cycle(1, 0, 32'h300, 32'h1, 1);
    cycle(0, 0, 32'h304, 32'h2, 1);
    repeat (3) cycle(1, 0, 32'h308, 32'h3, 1);
    chk("wd_before_limit", {31'd0, bus.deadlock}, 32'd0);
    cycle(1, 0, 32'h308, 32'h3, 1);
    chk("wd_at_limit", {31'd0, bus.deadlock}, 32'd1);
    repeat (2) cycle(0, 0, 32'h30C, 32'h4, 0);
    chk("wd_sticky", {31'd0, bus.deadlock}, 32'd1);

    // Stall counter saturation via backdoor preload
    do_reset();
    force dut.stall_cycles_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cycles_q;
    m_sc = 32'hFFFF_FFFE;
    repeat (3) cycle(1, 0, 32'h400, 32'h5, 1);
    chk("sc_saturate", bus.stall_cycles, 32'hFFFF_FFFF);

    // Randomized traffic
    do_reset();
    pc = 32'h1000;
    for (int i = 0; i < 300; i++) begin
      bit s, f, v;
      s = ($urandom_range(0, 99) < 30);
      f = ($urandom_range(0, 99) < 10);
      v = ($urandom_range(0, 99) < 85);
      cycle(s, f, pc, $urandom, v);
      if (f) pc = {$urandom_range(0, 16'hFFFF), 2'b00};
      else if (!s) pc = pc + 4;
    end

    // Asynchronous reset mid-cycle during a stall
    do_reset();
    repeat (2) cycle(0, 0, 32'h500, 32'h6, 1);
    repeat (2) cycle(1, 0, 32'h504, 32'h7, 1);
    #2;
    active = 0;
    q.delete();
    reset = 1;
    #1;
    check_reset("async");
    @(negedge clock);
    reset = 0;
    model_reset();
    active = 1;
    cycle(1, 0, 32'h600, 32'h8, 1);
    cycle(0, 0, 32'h604, 32'h9, 1);
    cycle(0, 0, 32'h608, 32'hA, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_stall_bubble.md
# decode_stall_bubble

Pipeline-register and bubble controller that consumes the decode-stage `stall` request and the execute-stage redirect `flush` in the 5-stage RV32I core. It owns the F/D and D/X instruction registers:
- On a stall it freezes fetch and decode and injects a NOP into execute.
- On a flush it squashes both younger stages.

It also keeps saturating stall/flush performance counters and a stall-deadlock watchdog.

## Interface
Parameters:
- `NOP_INST`, 32'h0000_0013, instruction word (ADDI x0,x0,0) loaded into a squashed or bubbled stage.
- `STALL_LIMIT`, 64, number of consecutive stall cycles that sets `deadlock`; legal range 2..65535.

Ports:
- `clock`  in  1  core clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high.
- `stall`  in  1  hazard stall request from decode-stage hazard detection.
- `flush`  in  1  taken branch/jump resolved in execute; younger instructions are wrong-path.
- `f_pc`  in  32  PC of the instruction in fetch.
- `f_inst`  in  32  instruction word from imem.
- `f_valid`  in  1  fetch output is a real instruction.
- `pc_enable`  out  1  PC register load enable (combinational).
- `d_pc`, `d_inst`  out  32 each  F/D register contents.
- `d_valid`  out  1  F/D holds a real instruction.
- `x_pc`, `x_inst`  out  32 each  D/X register contents.
- `x_valid`  out  1  D/X holds a real instruction.
- `stall_cycles`  out  32  saturating count of cycles spent stalled.
- `flush_count`  out  32  saturating count of flush events.
- `deadlock`  out  1  sticky watchdog flag.

## Operation
Per-cycle action, in priority order reset > flush > stall > advance.

Flush (`flush`=1, `stall` ignored):
- `d_inst`<=NOP_INST, `d_valid`<=0, `d_pc`<=`f_pc`.
- `x_inst`<=NOP_INST, `x_valid`<=0, `x_pc`<=`d_pc`.
- `flush_count`+=1.

Stall (`stall`=1, `flush`=0):
- F/D holds every field.
- D/X <= bubble: `x_inst`<=NOP_INST, `x_valid`<=0, `x_pc`<=`d_pc`.
- `stall_cycles`+=1.

Advance (both low):
- `d_*` <= `f_*`; `d_inst` <= `f_valid` ? `f_inst` : NOP_INST.
- `x_*` <= `d_*`.

PC and counters:
- `pc_enable` = !`stall` || `flush`. During a flush the PC must load the redirect target; the mux is external.
- Both counters saturate at 32'hFFFF_FFFF and never wrap.

Watchdog:
- Internal 16-bit `run_len` counts consecutive cycles with `stall`=1 && `flush`=0.
- It clears to 0 on any cycle where that condition is false and saturates at STALL_LIMIT.
- When `run_len` reaches STALL_LIMIT, `deadlock` is set and stays set until reset.

Watchdog state machine:
- IDLE: `run_len`=0. Go to STALLING on the first stall cycle.
- STALLING: increment each stall cycle. Go to IDLE on a non-stall cycle. Go to LOCKED when the count reaches STALL_LIMIT.
- LOCKED: `deadlock`=1. The pipeline keeps obeying `stall`/`flush`. Only reset exits.

## Timing
- Reset values:
  - `d_inst`=`x_inst`=NOP_INST.
  - `d_pc`=`x_pc`=0.
  - `d_valid`=`x_valid`=0.
  - Counters and `run_len` are 0; `deadlock`=0; watchdog state is IDLE.
- `pc_enable` is combinational from the inputs.
- An instruction presented at fetch with no hazards:
  - Appears at `d_*` one edge later.
  - Appears at `x_*` two edges later.
- A stall of N cycles delays everything behind decode by exactly N cycles and puts exactly N bubbles into D/X.
- `flush` with `stall` in the same cycle is treated as flush: `stall_cycles` is unchanged and `run_len` clears.
- Reset asserted mid-stall or mid-flush clears all state asynchronously. The first edge after deassertion performs a normal advance.
- `deadlock` rises on the edge that brings `run_len` to STALL_LIMIT. That means STALL_LIMIT consecutive stall cycles, with the flag visible after the STALL_LIMIT-th edge.

## Test plan
- Reset, then present f_pc=0x100 / 0x104 / 0x108 with f_valid=1, no stall: d_pc=0x100 after edge 1, x_pc=0x100 and d_pc=0x104 after edge 2; both valids high.
- Steady stream with `stall` high for 2 cycles while d_pc=0x104:
  - `d_*` holds 0x104 for both cycles and `pc_enable`=0.
  - x_inst=0x00000013 and x_valid=0 for 2 cycles, then x_pc=0x104 after release.
  - stall_cycles=2.
- `flush` with d_pc=0x108, f_pc=0x10C: next edge d_valid=0, x_valid=0, both insts=NOP_INST, flush_count=1. `flush` and `stall` together: same result, stall_cycles unchanged.
- STALL_LIMIT=4, `stall` held 3 cycles, dropped 1 cycle, then held 4 cycles: `deadlock` stays 0 through the first run and rises after the 4th edge of the second run. It stays 1 after `stall` drops and clears only on reset.
- Preload stall_cycles to 32'hFFFF_FFFE via a long stall (force/backdoor), then stall 3 more cycles: it reads 32'hFFFF_FFFF and does not wrap.
- Assert `reset` asynchronously, mid-clock, during a stall: all outputs return to reset values immediately, without waiting for an edge.
